// File: rtl/i2c_data_in_rx_if.sv
// i2c_data_in_rx_if: pad-side and register-file-side signals of the I2C
// write-path receiver, bundled so the parameterised buffer travels as one port.
//   slave  modport : receiver view (pads/enable in, status and buffer out)
//   master modport : bus/system view (drives pads and enable, observes status)
// NUM_BYTES must match the NUM_BYTES of the receiver bound to the interface.
interface i2c_data_in_rx_if #(
  parameter int unsigned NUM_BYTES = 6
);
  localparam int unsigned CW = $clog2(NUM_BYTES) + 1;

  logic          SCL;
  logic          SDA;
  logic          enable;
  logic          SDA_down;
  logic          addr_match;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [CW-1:0] rx_count;
  logic [7:0]    received_data [NUM_BYTES];
  logic          overflow;
  logic          done;

  modport slave (
    input  SCL, SDA, enable,
    output SDA_down, addr_match, byte_valid, byte_data, rx_count,
           received_data, overflow, done
  );

  modport master (
    output SCL, SDA, enable,
    input  SDA_down, addr_match, byte_valid, byte_data, rx_count,
           received_data, overflow, done
  );
endinterface

// File: rtl/i2c_data_in_rx.sv
// i2c_data_in_rx: I2C slave write-path receiver.
// Synchronises raw SCL/SDA, detects START / repeated START / STOP, matches a
// 7-bit write address and stores data bytes into a NUM_BYTES-deep buffer with
// ACK/NACK generation and sticky overflow.
// Ports:
//   FPGA_clk   system clock, rising edge
//   rst        synchronous active-high reset
//   bus        i2c_data_in_rx_if.slave:
//                SCL, SDA, enable                 (in)
//                SDA_down, addr_match, byte_valid, byte_data, rx_count,
//                received_data, overflow, done    (out, all registered)
module i2c_data_in_rx #(
  parameter int unsigned NUM_BYTES    = 6,
  parameter logic [6:0]  SLAVE_ADDR   = 7'h42,
  parameter bit          NACK_ON_FULL = 1'b1
) (
  input  logic                   FPGA_clk,
  input  logic                   rst,
  i2c_data_in_rx_if.slave        bus
);

  localparam int unsigned CW = $clog2(NUM_BYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t        r_state;

  // Two-flop synchronisers plus one history stage for edge detection
  logic          r_scl_meta, r_scl_sync, r_scl_prev;
  logic          r_sda_meta, r_sda_sync, r_sda_prev;

  logic [6:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_ack_drive;   // 1 = ACK the current byte, 0 = NACK
  logic          r_ack_phase;   // 0 = waiting for the fall ending bit 8

  logic          r_sda_down;
  logic          r_addr_match;
  logic          r_byte_valid;
  logic [7:0]    r_byte_data;
  logic [CW-1:0] r_rx_count;
  logic [7:0]    r_buf [NUM_BYTES];
  logic          r_overflow;
  logic          r_done;

  logic          w_scl_rise, w_scl_fall;
  logic          w_start, w_stop;
  logic [7:0]    w_byte;
  logic          w_addr_ok;
  logic          w_has_room;

  // Bus conditions from synchronised samples only
  assign w_scl_rise = r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_sync & r_scl_prev;
  assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

  // Byte as it will look once the current SDA sample is shifted in
  assign w_byte     = {r_shift, r_sda_sync};
  assign w_addr_ok  = (w_byte[7:1] == SLAVE_ADDR) && !w_byte[0];
  assign w_has_room = r_rx_count < CW'(NUM_BYTES);

  // Receiver state machine, synchronisers and output registers
  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_scl_meta   <= 1'b1;
      r_scl_sync   <= 1'b1;
      r_scl_prev   <= 1'b1;
      r_sda_meta   <= 1'b1;
      r_sda_sync   <= 1'b1;
      r_sda_prev   <= 1'b1;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_ack_drive  <= 1'b0;
      r_ack_phase  <= 1'b0;
      r_sda_down   <= 1'b0;
      r_addr_match <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_rx_count   <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < int'(NUM_BYTES); i++) r_buf[i] <= '0;
    end else begin
      r_scl_meta   <= bus.SCL;
      r_scl_sync   <= r_scl_meta;
      r_scl_prev   <= r_scl_sync;
      r_sda_meta   <= bus.SDA;
      r_sda_sync   <= r_sda_meta;
      r_sda_prev   <= r_sda_sync;

      r_byte_valid <= 1'b0;
      r_done       <= 1'b0;

      if (w_start || w_stop) begin
        // Bus conditions override bit sampling; any partial byte is dropped
        r_sda_down   <= 1'b0;
        r_bit_cnt    <= '0;
        r_ack_phase  <= 1'b0;
        r_addr_match <= 1'b0;
        if (r_addr_match) r_done <= 1'b1;
        if (w_stop)          r_state <= S_IDLE;
        else if (bus.enable) r_state <= S_ADDR;
        else                 r_state <= S_IGNORE;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (w_addr_ok) begin
                  r_state      <= S_ADDR_ACK;
                  r_rx_count   <= '0;
                  r_overflow   <= 1'b0;
                  r_addr_match <= 1'b1;
                  r_ack_drive  <= 1'b1;
                  r_ack_phase  <= 1'b0;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end

          S_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state     <= S_DATA_ACK;
                r_ack_phase <= 1'b0;
                if (w_has_room) begin
                  for (int i = 0; i < int'(NUM_BYTES); i++) begin
                    if (r_rx_count == CW'(i)) r_buf[i] <= w_byte;
                  end
                  r_byte_data  <= w_byte;
                  r_byte_valid <= 1'b1;
                  r_rx_count   <= r_rx_count + CW'(1);
                  r_ack_drive  <= 1'b1;
                end else begin
                  r_overflow  <= 1'b1;
                  r_ack_drive <= !NACK_ON_FULL;
                end
              end
            end
          end

          // ACK window spans from the fall ending bit 8 to the fall ending bit 9
          S_ADDR_ACK, S_DATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_down  <= r_ack_drive;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_down  <= 1'b0;
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= '0;
                r_state     <= S_DATA;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign bus.SDA_down      = r_sda_down;
  assign bus.addr_match    = r_addr_match;
  assign bus.byte_valid    = r_byte_valid;
  assign bus.byte_data     = r_byte_data;
  assign bus.rx_count      = r_rx_count;
  assign bus.received_data = r_buf;
  assign bus.overflow      = r_overflow;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_i2c_data_in_rx.sv
// Bench for i2c_data_in_rx: three receivers (6-deep NACK-on-full, 2-deep
// NACK-on-full, 2-deep ACK-and-discard) share one bit-banged I2C master.
// A byte-level transaction model predicts ACKs, stored bytes, counts and done.
module tb_i2c_data_in_rx;

  logic clk = 1'b0;
  logic rst;
  logic scl, sda, en;

  always #5 clk = ~clk;

  i2c_data_in_rx_if #(.NUM_BYTES(6)) if0 ();
  i2c_data_in_rx_if #(.NUM_BYTES(2)) if1 ();
  i2c_data_in_rx_if #(.NUM_BYTES(2)) if2 ();

  assign if0.SCL = scl;  assign if0.SDA = sda;  assign if0.enable = en;
  assign if1.SCL = scl;  assign if1.SDA = sda;  assign if1.enable = en;
  assign if2.SCL = scl;  assign if2.SDA = sda;  assign if2.enable = en;

  i2c_data_in_rx #(.NUM_BYTES(6), .SLAVE_ADDR(7'h42), .NACK_ON_FULL(1'b1))
    u0 (.FPGA_clk(clk), .rst(rst), .bus(if0));
  i2c_data_in_rx #(.NUM_BYTES(2), .SLAVE_ADDR(7'h42), .NACK_ON_FULL(1'b1))
    u1 (.FPGA_clk(clk), .rst(rst), .bus(if1));
  i2c_data_in_rx #(.NUM_BYTES(2), .SLAVE_ADDR(7'h42), .NACK_ON_FULL(1'b0))
    u2 (.FPGA_clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic           down;
    logic           match;
    logic           valid;
    logic           ovf;
    logic           done;
    logic [7:0]     bdata;
    logic [7:0]     cnt;
    logic [5:0][7:0] bufv;
  } obs_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, per receiver
  int         m_nb  [3] = '{6, 2, 2};
  bit         m_nof [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] m_buf [3][6];
  int         m_cnt [3];
  bit         m_ovf [3], m_match [3], m_active [3], m_listen [3];
  int         exp_done [3], got_done [3];
  logic [7:0] exp_b [3][64], got_b [3][64];
  int         exp_n [3], got_n [3];

  // Capture stored-byte pulses and done pulses between checkpoints
  always @(negedge clk) begin
    if (if0.byte_valid) begin got_b[0][got_n[0] % 64] = if0.byte_data; got_n[0]++; end
    if (if1.byte_valid) begin got_b[1][got_n[1] % 64] = if1.byte_data; got_n[1]++; end
    if (if2.byte_valid) begin got_b[2][got_n[2] % 64] = if2.byte_data; got_n[2]++; end
    if (if0.done) got_done[0]++;
    if (if1.done) got_done[1]++;
    if (if2.done) got_done[2]++;
  end

  function automatic obs_t get_obs(input int k);
    obs_t o;
    o = '0;
    case (k)
      0: begin
        o.down = if0.SDA_down; o.match = if0.addr_match; o.valid = if0.byte_valid;
        o.ovf = if0.overflow; o.done = if0.done; o.bdata = if0.byte_data;
        o.cnt = 8'(if0.rx_count);
        for (int i = 0; i < 6; i++) o.bufv[i] = if0.received_data[3'(i)];
      end
      1: begin
        o.down = if1.SDA_down; o.match = if1.addr_match; o.valid = if1.byte_valid;
        o.ovf = if1.overflow; o.done = if1.done; o.bdata = if1.byte_data;
        o.cnt = 8'(if1.rx_count);
        for (int i = 0; i < 2; i++) o.bufv[i] = if1.received_data[1'(i)];
      end
      default: begin
        o.down = if2.SDA_down; o.match = if2.addr_match; o.valid = if2.byte_valid;
        o.ovf = if2.overflow; o.done = if2.done; o.bdata = if2.byte_data;
        o.cnt = 8'(if2.rx_count);
        for (int i = 0; i < 2; i++) o.bufv[i] = if2.received_data[1'(i)];
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void m_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) m_buf[k][i] = 8'h00;
      m_cnt[k] = 0; m_ovf[k] = 0; m_match[k] = 0; m_active[k] = 0; m_listen[k] = 0;
    end
  endfunction

  function automatic void m_start();
    for (int k = 0; k < 3; k++) begin
      if (m_match[k]) exp_done[k]++;
      m_match[k] = 0; m_active[k] = 0; m_listen[k] = en;
    end
  endfunction

  function automatic void m_stop();
    for (int k = 0; k < 3; k++) begin
      if (m_match[k]) exp_done[k]++;
      m_match[k] = 0; m_active[k] = 0; m_listen[k] = 0;
    end
  endfunction

  // Returns the expected ACK (1) / NACK (0) per receiver for a full byte
  function automatic logic [2:0] m_byte(input logic [7:0] b);
    logic [2:0] ack;
    ack = '0;
    for (int k = 0; k < 3; k++) begin
      if (m_listen[k]) begin
        m_listen[k] = 0;
        if (b == 8'h84) begin
          m_match[k] = 1; m_active[k] = 1; m_cnt[k] = 0; m_ovf[k] = 0;
          ack[k] = 1'b1;
        end
      end else if (m_active[k]) begin
        if (m_cnt[k] < m_nb[k]) begin
          m_buf[k][m_cnt[k]] = b;
          exp_b[k][exp_n[k] % 64] = b; exp_n[k]++;
          m_cnt[k]++;
          ack[k] = 1'b1;
        end else begin
          m_ovf[k] = 1;
          ack[k] = !m_nof[k];
        end
      end
    end
    return ack;
  endfunction

  // ---------------- bus master ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda = 1'b1; wait_clk(4);
      scl = 1'b1; wait_clk(8);
    end
    sda = 1'b0; wait_clk(8);
    scl = 1'b0; wait_clk(4);
    m_start();
  endtask

  task automatic bus_stop();
    sda = 1'b0; wait_clk(4);
    scl = 1'b1; wait_clk(8);
    sda = 1'b1; wait_clk(8);
    m_stop();
  endtask

  task automatic send_bit(input logic b, output logic [2:0] d);
    obs_t o0, o1, o2;
    sda = b;    wait_clk(4);
    scl = 1'b1; wait_clk(4);
    o0 = get_obs(0); o1 = get_obs(1); o2 = get_obs(2);
    d = {o2.down, o1.down, o0.down};
    wait_clk(4);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [2:0] d, any, ack_exp;
    any = '0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], d);
      any |= d;
    end
    ack_exp = m_byte(b);
    send_bit(1'b1, d);
    chk($sformatf("sda_down_in_bits_%02h", b), 32'(any), 32'(0));
    for (int k = 0; k < 3; k++)
      chk($sformatf("ack_dut%0d_byte_%02h", k, b), 32'(d[k]), 32'(ack_exp[k]));
  endtask

  task automatic send_partial(input int nbits);
    logic [2:0] d;
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), d);
  endtask

  // ---------------- checkpoints ----------------
  task automatic check_all(input string tag);
    obs_t o;
    wait_clk(4);
    for (int k = 0; k < 3; k++) begin
      o = get_obs(k);
      chk($sformatf("%s_dut%0d_rx_count", tag, k), 32'(o.cnt), 32'(m_cnt[k]));
      chk($sformatf("%s_dut%0d_overflow", tag, k), 32'(o.ovf), 32'(m_ovf[k]));
      chk($sformatf("%s_dut%0d_addr_match", tag, k), 32'(o.match), 32'(m_match[k]));
      for (int i = 0; i < m_nb[k]; i++)
        chk($sformatf("%s_dut%0d_buf%0d", tag, k, i), 32'(o.bufv[i]), 32'(m_buf[k][i]));
      chk($sformatf("%s_dut%0d_valid_count", tag, k), 32'(got_n[k]), 32'(exp_n[k]));
      for (int i = 0; i < exp_n[k] && i < got_n[k] && i < 64; i++)
        chk($sformatf("%s_dut%0d_byte_data%0d", tag, k, i), 32'(got_b[k][i]), 32'(exp_b[k][i]));
      chk($sformatf("%s_dut%0d_done_count", tag, k), 32'(got_done[k]), 32'(exp_done[k]));
      got_n[k] = 0; exp_n[k] = 0; got_done[k] = 0; exp_done[k] = 0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      o = get_obs(k);
      chk($sformatf("%s_dut%0d_sda_down", tag, k), 32'(o.down), 32'(0));
      chk($sformatf("%s_dut%0d_flags", tag, k),
          32'({o.match, o.valid, o.ovf, o.done}), 32'(0));
      chk($sformatf("%s_dut%0d_byte_data", tag, k), 32'(o.bdata), 32'(0));
      chk($sformatf("%s_dut%0d_rx_count", tag, k), 32'(o.cnt), 32'(0));
      chk($sformatf("%s_dut%0d_buffer", tag, k), 32'(o.bufv[0] | o.bufv[1] | o.bufv[2] |
          o.bufv[3] | o.bufv[4] | o.bufv[5]), 32'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obs_t o;
    logic [2:0] d;
    logic [7:0] addr;
    int nbytes, pick;

    rst = 1'b1; scl = 1'b1; sda = 1'b1; en = 1'b1;
    m_reset();
    for (int k = 0; k < 3; k++) begin
      exp_done[k] = 0; got_done[k] = 0; exp_n[k] = 0; got_n[k] = 0;
    end
    wait_clk(5);
    check_reset_state("reset");
    rst = 1'b0;
    wait_clk(5);

    // Basic write of three bytes
    bus_start(); send_byte(8'h84);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
    bus_stop(); check_all("write3");

    // Wrong address, then a read to our address: nothing may change
    bus_start(); send_byte(8'h86); send_byte(8'h12); bus_stop();
    bus_start(); send_byte(8'h85); send_byte(8'h34); bus_stop();
    check_all("no_match");

    // Overflow on the 2-deep receivers
    bus_start(); send_byte(8'h84);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    bus_stop(); check_all("overflow");

    // Partial byte then repeated START
    bus_start(); send_byte(8'h84); send_partial(5);
    bus_start(); send_byte(8'h84); send_byte(8'h77);
    bus_stop(); check_all("rep_start");

    // Disabled at START: transaction ignored
    en = 1'b0;
    bus_start(); send_byte(8'h84); send_byte(8'h55); bus_stop();
    en = 1'b1;
    check_all("disabled");

    // Reset during the address ACK low phase
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      addr = 8'h84;
      send_bit(addr[i], d);
    end
    wait_clk(2);
    o = get_obs(0);
    chk("ack_window_before_rst", 32'(o.down), 32'(1));
    rst = 1'b1;
    wait_clk(1);
    check_reset_state("mid_rst");
    rst = 1'b0;
    m_reset();
    for (int k = 0; k < 3; k++) begin
      exp_done[k] = 0; got_done[k] = 0; exp_n[k] = 0; got_n[k] = 0;
    end
    bus_stop();
    bus_start(); send_byte(8'h84); send_byte(8'hC3); send_byte(8'h5A);
    bus_stop(); check_all("after_rst");

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      en = ($urandom_range(0, 7) != 0);
      pick = int'($urandom_range(0, 7));
      if (pick < 5)       addr = 8'h84;
      else if (pick == 5) addr = 8'h85;
      else                addr = 8'($urandom_range(0, 255));
      bus_start();
      send_byte(addr);
      nbytes = int'($urandom_range(0, 4));
      for (int i = 0; i < nbytes; i++) send_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) send_partial(int'($urandom_range(1, 6)));
      if ($urandom_range(0, 3) != 0) bus_stop();
      check_all($sformatf("rand%0d", t));
    end
    if (scl == 1'b0) bus_stop();
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_data_in_rx.md
# i2c_data_in_rx

Parametrised I2C slave write-path receiver, the successor to the fixed 6-byte data-in controller. It takes raw SCL/SDA from the pads and synchronises them to `FPGA_clk`. It detects START, repeated START and STOP itself and matches a 7-bit slave address. Addressed write bytes go into a NUM_BYTES-deep register buffer, with ACK/NACK generation and overflow handling; it sits between the pad I/O cell (open-drain SDA pull-down) and the register-file front end.

## Interface
- NUM_BYTES, 6: buffer depth in bytes (≥1).
- SLAVE_ADDR, 7'h42: 7-bit address this slave answers to.
- NACK_ON_FULL, 1: 1 = NACK bytes arriving when buffer full; 0 = ACK and discard.
- FPGA_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SCL  in  1  raw bus clock (asynchronous to FPGA_clk).
- SDA  in  1  raw bus data (asynchronous).
- enable  in  1  slave enable; sampled only at START detection.
- SDA_down  out  1  1 = pull SDA low (ACK).
- addr_match  out  1  high from address ACK until STOP/repeated START.
- byte_valid  out  1  one-cycle pulse per stored byte.
- byte_data  out  8  byte just stored (valid with byte_valid).
- rx_count  out  $clog2(NUM_BYTES)+1  bytes stored in current transaction.
- received_data  out  8 x NUM_BYTES  unpacked buffer, index 0 = first byte.
- overflow  out  1  sticky: ≥1 byte arrived while full this transaction.
- done  out  1  one-cycle pulse at end of an addressed transaction.

## Operation
- Reset: all outputs 0, buffer all 0, state IDLE, synchronisers loaded with 1 (bus idle).
- SCL/SDA pass through 2-flop synchronisers. A third register gives SCL_prev/SDA_prev. Edges and conditions use synchronised values only.
- START: SDA 1→0 while SCL high. STOP: SDA 0→1 while SCL high. Both are recognised in every state and take priority over bit sampling in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START with enable=1 → ADDR, bit counter=0. START with enable=0 → IGNORE.
- ADDR: shift SDA MSB-first on each SCL rise. After the 8th bit, compare [7:1] with SLAVE_ADDR and require R/W bit [0]=0.
  - Match → ADDR_ACK: rx_count←0, overflow←0, addr_match←1.
  - Mismatch or read → IGNORE.
- ADDR_ACK / DATA_ACK (when ACKing): SDA_down=1 from the SCL fall after the 8th bit to the SCL fall after the 9th bit, then → DATA. A NACK keeps SDA_down=0 for the same window.
- DATA: shift 8 bits on SCL rises. On the 8th rise:
  - If rx_count<NUM_BYTES: received_data[rx_count]←byte, byte_data←byte, byte_valid pulse, rx_count+1, → DATA_ACK with ACK.
  - Else: overflow←1, no store, → DATA_ACK with NACK if NACK_ON_FULL=1, otherwise ACK.
- IGNORE: SDA_down stays 0. Only START/STOP are acted on.
- Repeated START in any state:
  - Partial byte is discarded.
  - If addr_match=1: done pulse, addr_match←0.
  - → ADDR (enable=1) or IGNORE (enable=0).
- STOP in any state: done pulse if addr_match=1, addr_match←0, SDA_down←0, → IDLE.
- received_data and rx_count hold after STOP until the next address match (rx_count cleared then) or reset. The buffer is overwritten in place, never cleared by START.
- rst mid-transaction returns to reset values on the next edge; SDA_down is released immediately.

## Timing
- Pad-to-detect latency: 3 FPGA_clk cycles from a raw SCL/SDA change to the corresponding edge/START/STOP decision. Bus SCL high/low phases must each be ≥4 FPGA_clk cycles.
- byte_valid, byte_data, received_data update and rx_count increment happen in the same cycle, 1 cycle after the detected 8th SCL rise.
- SDA_down asserts 1 cycle after the detected SCL fall that ends bit 8. It deasserts 1 cycle after the detected SCL fall that ends bit 9.
- done: single cycle, 1 cycle after STOP/repeated-START detection. No dependency on byte_valid timing.
- rx_count saturates at NUM_BYTES and never wraps. Width is $clog2(NUM_BYTES)+1, so NUM_BYTES itself is representable.
- SDA toggling while SCL high during a data bit is a START/STOP by definition, never a data bit.

## Test plan
- Addr 0x42 write, bytes A5,3C,FF, STOP → ACK on all 4 ACK slots; received_data[0..2]=A5,3C,FF; 3 byte_valid pulses; rx_count=3; done pulses once; overflow=0.
- Addr 0x43, then addr 0x42 with R/W=1 → SDA_down never asserts, no byte_valid, no done, buffer unchanged.
- NUM_BYTES=2, NACK_ON_FULL=1, write 11,22,33 → first two ACKed and stored; third NACKed and not stored; rx_count=2; overflow=1.
- Repeat the 3-byte overflow case with NACK_ON_FULL=0 → third byte ACKed and discarded, overflow=1.
- Write 5 bits of a byte then repeated START + addr 0x42 + byte 77 + STOP → partial byte dropped; done pulses at repeated START and at STOP; received_data[0]=77; rx_count=1.
- Assert rst during the ADDR_ACK low phase → SDA_down=0 next cycle, all outputs 0. The next full write from START then completes normally.
